// File: rtl/rtype_pkg.sv
// Shared constants and instruction field layout for the R-type datapath.
// Optional build macro: RTYPE_NOR_EN (adds NOR on funct 001100).
package rtype_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam logic [5:0] FN_AND = 6'b000000;
   localparam logic [5:0] FN_OR  = 6'b000001;
   localparam logic [5:0] FN_ADD = 6'b000010;
   localparam logic [5:0] FN_SUB = 6'b000110;
   localparam logic [5:0] FN_SLT = 6'b000111;
   localparam logic [5:0] FN_NOR = 6'b001100;

   typedef struct packed {
      logic [5:0]        op;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
      logic [ADDR_W-1:0] rd;
      logic [4:0]        shamt;
      logic [5:0]        funct;
   } rtype_instr_t;

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU; valid is low for any funct it does not implement.
// Optional build macro: RTYPE_NOR_EN (adds NOR on funct 001100).
module rtype_alu
   import rtype_pkg::*;
#(
   parameter int W = rtype_pkg::DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [5:0]   funct,
   output logic [W-1:0] result,
   output logic         valid
);

   always_comb begin
      result = '0;
      valid  = 1'b1;
      case (funct)
         FN_AND: result = a & b;
         FN_OR:  result = a | b;
         FN_ADD: result = a + b;
         FN_SUB: result = a - b;
         FN_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef RTYPE_NOR_EN
         FN_NOR: result = ~(a | b);
`endif
         default: begin
            result = '0;
            valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rtype_datapath.sv
// Single-cycle R-type execute: register file, ALU, writeback and registered zero flag.
// Optional build macro: RTYPE_NOR_EN (adds NOR on funct 001100).
module rtype_datapath
   import rtype_pkg::*;
#(
   parameter int DATA_W  = rtype_pkg::DATA_W,
   parameter int REG_NUM = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruccion_r,
   output logic              tr_zf,
   output logic [DATA_W-1:0] alu_res
);

   rtype_instr_t      instr;
   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic [DATA_W-1:0] regs_d [REG_NUM];
   logic              zf_q, zf_d;
   logic [DATA_W-1:0] rs_val, rt_val, alu_out;
   logic              alu_valid, exec_ok;
   logic              unused_shamt;

   assign instr        = rtype_instr_t'(instruccion_r);
   assign unused_shamt = ^instr.shamt;

   // r0 is forced to zero on read regardless of what the array holds.
   assign rs_val = (instr.rs == '0) ? '0 : regs_q[instr.rs];
   assign rt_val = (instr.rt == '0) ? '0 : regs_q[instr.rt];

   rtype_alu #(.W(DATA_W)) u_alu (
      .a      (rs_val),
      .b      (rt_val),
      .funct  (instr.funct),
      .result (alu_out),
      .valid  (alu_valid)
   );

   assign exec_ok = (instr.op == OP_RTYPE) && alu_valid;
   assign alu_res = exec_ok ? alu_out : '0;
   assign tr_zf   = zf_q;

   always_comb begin
      regs_d = regs_q;
      zf_d   = zf_q;
      if (exec_ok) begin
         zf_d = (alu_res == '0);
         if (instr.rd != '0) regs_d[instr.rd] = alu_res;
      end
   end

   // Reset loads the identity pattern so each register reads back its own index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < REG_NUM; k++) regs_q[k] <= DATA_W'(k);
         zf_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         zf_q   <= zf_d;
      end
   end

endmodule

// File: tb/tb_rtype_datapath.sv
// Directed bench for rtype_datapath; registers are observed through OR rs=k,rt=r0 reads.
module tb_rtype_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruccion_r;
   logic        tr_zf;
   logic [31:0] alu_res;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [31:0] NOP = 32'h0400_0000; // op=000001, never executed

   rtype_datapath dut (
      .clk           (clk),
      .rst           (rst),
      .instruccion_r (instruccion_r),
      .tr_zf         (tr_zf),
      .alu_res       (alu_res)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [5:0] fn, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   // Present an instruction, capture the pre-edge alu_res, then let it retire.
   task automatic run(input logic [31:0] ins, output logic [31:0] res);
      @(negedge clk);
      instruccion_r = ins;
      #1 res = alu_res;
      @(posedge clk);
      #1 instruccion_r = NOP;
   endtask

   // Read a register combinationally without any edge acting on it.
   task automatic peek(input logic [4:0] k, output logic [31:0] v);
      @(negedge clk);
      instruccion_r = mk(6'b000001, k, 5'd0, 5'd0);
      #1 v = alu_res;
      instruccion_r = NOP;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL reset_zf got %0b exp 0", tr_zf); else n_pass++;
      peek(5'd0, v);
      n_chk++; if (v !== 32'd0) $display("FAIL reset_r0 got %h exp 0", v); else n_pass++;
      peek(5'd5, v);
      n_chk++; if (v !== 32'd5) $display("FAIL reset_r5 got %h exp 5", v); else n_pass++;
      peek(5'd31, v);
      n_chk++; if (v !== 32'd31) $display("FAIL reset_r31 got %h exp 31", v); else n_pass++;
   endtask

   task automatic test_and();
      logic [31:0] r, v;
      run(mk(6'b000000, 5'd5, 5'd1, 5'd0), r);
      n_chk++; if (r !== 32'd1) $display("FAIL and_r0_res got %h exp 1", r); else n_pass++;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL and_r0_zf got %0b exp 0", tr_zf); else n_pass++;
      peek(5'd0, v);
      n_chk++; if (v !== 32'd0) $display("FAIL and_r0_keep got %h exp 0", v); else n_pass++;
      run(mk(6'b000000, 5'd6, 5'd4, 5'd10), r);
      n_chk++; if (r !== 32'd4) $display("FAIL and_res got %h exp 4", r); else n_pass++;
      peek(5'd10, v);
      n_chk++; if (v !== 32'd4) $display("FAIL and_r10 got %h exp 4", v); else n_pass++;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL and_zf got %0b exp 0", tr_zf); else n_pass++;
   endtask

   task automatic test_or_add();
      logic [31:0] r, v;
      run(mk(6'b000001, 5'd9, 5'd7, 5'd4), r);
      peek(5'd4, v);
      n_chk++; if (v !== 32'd15) $display("FAIL or_r4 got %h exp 15", v); else n_pass++;
      run(mk(6'b000010, 5'd12, 5'd10, 5'd11), r);
      n_chk++; if (r !== 32'd16) $display("FAIL add_res got %h exp 16", r); else n_pass++;
      peek(5'd11, v);
      n_chk++; if (v !== 32'd16) $display("FAIL add_r11 got %h exp 16", v); else n_pass++;
   endtask

   task automatic test_sub_slt();
      logic [31:0] r, v;
      run(mk(6'b000110, 5'd13, 5'd13, 5'd14), r);
      peek(5'd14, v);
      n_chk++; if (v !== 32'd0) $display("FAIL sub_r14 got %h exp 0", v); else n_pass++;
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL sub_zf got %0b exp 1", tr_zf); else n_pass++;
      run(mk(6'b000111, 5'd3, 5'd5, 5'd22), r);
      peek(5'd22, v);
      n_chk++; if (v !== 32'd1) $display("FAIL slt_r22 got %h exp 1", v); else n_pass++;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL slt_zf got %0b exp 0", tr_zf); else n_pass++;
      // r20 = 0 - 1 wraps to all ones
      run(mk(6'b000110, 5'd0, 5'd1, 5'd20), r);
      n_chk++; if (r !== 32'hFFFF_FFFF) $display("FAIL sub_wrap got %h exp ffffffff", r); else n_pass++;
      run(mk(6'b000111, 5'd20, 5'd1, 5'd21), r);
      n_chk++; if (r !== 32'd1) $display("FAIL slt_neg got %h exp 1", r); else n_pass++;
      run(mk(6'b000111, 5'd1, 5'd20, 5'd23), r);
      n_chk++; if (r !== 32'd0) $display("FAIL slt_pos got %h exp 0", r); else n_pass++;
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL slt_pos_zf got %0b exp 1", tr_zf); else n_pass++;
      run(mk(6'b000010, 5'd20, 5'd2, 5'd24), r);
      n_chk++; if (r !== 32'd1) $display("FAIL add_wrap got %h exp 1", r); else n_pass++;
   endtask

   task automatic test_unsupported();
      logic [31:0] r, v;
      run(mk(6'b000110, 5'd7, 5'd7, 5'd0), r); // rd=0 still sets the flag
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL zf_rd0 got %0b exp 1", tr_zf); else n_pass++;
      run(mk(6'b000011, 5'd9, 5'd7, 5'd4), r);
      n_chk++; if (r !== 32'd0) $display("FAIL bad_fn_res got %h exp 0", r); else n_pass++;
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL bad_fn_zf got %0b exp 1", tr_zf); else n_pass++;
      run({6'b000001, 5'd9, 5'd7, 5'd4, 5'd0, 6'b000010}, r);
      n_chk++; if (r !== 32'd0) $display("FAIL bad_op_res got %h exp 0", r); else n_pass++;
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL bad_op_zf got %0b exp 1", tr_zf); else n_pass++;
      peek(5'd4, v);
      n_chk++; if (v !== 32'd15) $display("FAIL bad_r4 got %h exp 15", v); else n_pass++;
      run(mk(6'b001100, 5'd0, 5'd0, 5'd1), r);
      peek(5'd1, v);
`ifdef RTYPE_NOR_EN
      n_chk++; if (r !== 32'hFFFF_FFFF) $display("FAIL nor_res got %h exp ffffffff", r); else n_pass++;
      n_chk++; if (v !== 32'hFFFF_FFFF) $display("FAIL nor_r1 got %h exp ffffffff", v); else n_pass++;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL nor_zf got %0b exp 0", tr_zf); else n_pass++;
`else
      n_chk++; if (r !== 32'd0) $display("FAIL nor_off_res got %h exp 0", r); else n_pass++;
      n_chk++; if (v !== 32'd1) $display("FAIL nor_off_r1 got %h exp 1", v); else n_pass++;
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL nor_off_zf got %0b exp 1", tr_zf); else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] r, v;
      run(mk(6'b000010, 5'd4, 5'd4, 5'd4), r); // rd==rs==rt uses pre-write r4=15
      n_chk++; if (r !== 32'd30) $display("FAIL rdw_res got %h exp 30", r); else n_pass++;
      peek(5'd4, v);
      n_chk++; if (v !== 32'd30) $display("FAIL rdw_r4 got %h exp 30", v); else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [31:0] r, v;
      run(mk(6'b000110, 5'd8, 5'd8, 5'd0), r);
      n_chk++; if (tr_zf !== 1'b1) $display("FAIL pre_rst_zf got %0b exp 1", tr_zf); else n_pass++;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_chk++; if (tr_zf !== 1'b0) $display("FAIL async_zf got %0b exp 0", tr_zf); else n_pass++;
      instruccion_r = mk(6'b000001, 5'd4, 5'd0, 5'd0);
      #0.5;
      n_chk++; if (alu_res !== 32'd4) $display("FAIL async_r4 got %h exp 4", alu_res); else n_pass++;
      instruccion_r = NOP;
      run(mk(6'b000000, 5'd6, 5'd4, 5'd10), r); // must not write while in reset
      peek(5'd10, v);
      n_chk++; if (v !== 32'd10) $display("FAIL rst_block_r10 got %h exp 10", v); else n_pass++;
      peek(5'd11, v);
      n_chk++; if (v !== 32'd11) $display("FAIL async_r11 got %h exp 11", v); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      peek(5'd22, v);
      n_chk++; if (v !== 32'd22) $display("FAIL post_rst_r22 got %h exp 22", v); else n_pass++;
   endtask

   initial begin
      instruccion_r = NOP;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_and();
      test_or_add();
      test_sub_slt();
      test_unsupported();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
